// File: rtl/mips_pkg.sv
// Shared definitions for the instruction cache: line geometry, FSM states
// and helpers that split a fetch address into its cache fields.
package mips_pkg;

    localparam int LINE_WORDS     = 4;
    localparam int OFFSET_BITS    = 2;
    localparam int LINE_BYTE_BITS = OFFSET_BITS + 2;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_t;

    // Set index of an address, right-aligned in a 32-bit word.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits);
        logic [31:0] mask;
        mask = (32'd1 << index_bits) - 32'd1;
        return (addr >> LINE_BYTE_BITS) & mask;
    endfunction

    // Tag of an address (everything above the index), right-aligned.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits);
        return addr >> (LINE_BYTE_BITS + index_bits);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// The read port is purely combinational so hits cost no cycles. Writes,
// the tag update and the valid clear all take effect on the clock edge.
module icache_array
    import mips_pkg::*;
#(
    parameter int SETS = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - LINE_BYTE_BITS - IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    // combinational read port
    input  logic [IDX_W-1:0]       rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [31:0]            rd_data,
    // word write port used during a refill
    input  logic                   word_wr_en,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [31:0]            wr_data,
    // tag write, which also marks the line valid
    input  logic                   tag_wr_en,
    input  logic [TAG_W-1:0]       wr_tag,
    // valid clear at the start of a refill
    input  logic                   clr_en,
    input  logic [IDX_W-1:0]       clr_index
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];
    logic [31:0]      data_d [SETS][LINE_WORDS];

    // Read port: the line selected by the current fetch address.
    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_q[rd_index];
        rd_data  = data_q[rd_index][rd_offset];
    end

    // Next-state of the storage: apply whichever writes are requested.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr_en) begin
            valid_d[clr_index] = 1'b0;
        end
        if (word_wr_en) begin
            data_d[wr_index][wr_offset] = wr_data;
        end
        if (tag_wr_en) begin
            tag_d[wr_index]   = wr_tag;
            valid_d[wr_index] = 1'b1;
        end
    end

    // Valid bits are the only storage that reset touches.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache. Hits return the word in the
// same cycle; a miss stalls the core while a 4-word line is fetched one
// word per mem_ack from main memory.
module instr_cache
    import mips_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - LINE_BYTE_BITS - IDX_W;

    icache_state_t          state_q, state_d;
    logic [OFFSET_BITS-1:0] k_q, k_d;
    logic [31:4]            line_base_q, line_base_d;

    logic [IDX_W-1:0]       pc_index;
    logic [TAG_W-1:0]       pc_tag;
    logic [OFFSET_BITS-1:0] pc_offset;
    logic [IDX_W-1:0]       refill_index;
    logic [TAG_W-1:0]       refill_tag;

    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [31:0]            rd_data;
    logic                   hit;
    logic                   word_wr_en;
    logic                   tag_wr_en;
    logic                   clr_en;

    // Split the fetch address and the latched refill line into cache fields.
    always_comb begin
        pc_index     = IDX_W'(addr_index(pc, IDX_W));
        pc_tag       = TAG_W'(addr_tag(pc, IDX_W));
        pc_offset    = pc[3:2];
        refill_index = line_base_q[4 +: IDX_W];
        refill_tag   = line_base_q[31 -: TAG_W];
    end

    icache_array #(
        .SETS (SETS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (pc_index),
        .rd_offset  (pc_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .word_wr_en (word_wr_en),
        .wr_index   (refill_index),
        .wr_offset  (k_q),
        .wr_data    (mem_rdata),
        .tag_wr_en  (tag_wr_en),
        .wr_tag     (refill_tag),
        .clr_en     (clr_en),
        .clr_index  (pc_index)
    );

    // Hit detection and core/memory-facing outputs.
    always_comb begin
        hit      = rd_valid && (rd_tag == pc_tag);
        instr    = rd_data;
        stall    = (state_q == REFILL) || !hit;
        mem_req  = (state_q == REFILL);
        mem_addr = (state_q == REFILL) ? {line_base_q, k_q, 2'b00} : 32'd0;
    end

    // Refill FSM: latch the missing line, then accept one word per ack.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        line_base_d = line_base_q;
        word_wr_en  = 1'b0;
        tag_wr_en   = 1'b0;
        clr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    line_base_d = pc[31:4];
                    k_d         = '0;
                    clr_en      = 1'b1;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    word_wr_en = 1'b1;
                    k_d        = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        tag_wr_en = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, word counter and latched line address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            line_base_q <= line_base_d;
        end
    end

endmodule
